tia_range_sequencer: RTL and testbench
======================================

TIA_RANGE_SEQUENCER -- requirements
Module: tia_range_sequencer

Interface
REQ-001 Parameter ADC_W, default 12, ADC sample width.
REQ-002 Parameter SETTLE_W, default 16, settle counter width.
REQ-003 Parameter HI_THR, default 12'hF00, saturation threshold (inclusive).
REQ-004 Parameter LO_THR, default 12'h0FF, underrange threshold (inclusive).
REQ-005 Parameter MAX_AVG_LOG2, default 4, largest averaging exponent.
REQ-006 The clock is ACLK, input, 1 bit; all logic SHALL be on its rising edge.
REQ-007 ARESET is an input, 1 bit, synchronous, active-high reset.
REQ-008 start, input, 1 bit: one-cycle measurement request.
REQ-009 abort, input, 1 bit: cancel the measurement in progress.
REQ-010 cfg_gain, input, 2 bits: initial gain code, 0 = lowest transimpedance.
REQ-011 cfg_settle, input, SETTLE_W bits: settle cycles after each gain change.
REQ-012 cfg_avg_log2, input, 3 bits: average over 2^n samples; values above MAX_AVG_LOG2 are clipped to MAX_AVG_LOG2.
REQ-013 tia_gain, output, 2 bits: gain select driven to the TIA range switches.
REQ-014 adc_req / adc_ack / adc_data: output 1 / input 1 / input ADC_W bits, ADC conversion handshake.
REQ-015 busy, done, range_err, outputs, 1 bit each; result, output, ADC_W bits; result_gain, output, 2 bits.

Function
REQ-016 States SHALL be IDLE, SETTLE, PROBE, ACCUM and DONE; busy SHALL be 1 in every state except IDLE.
REQ-017 IDLE + start: latch cfg_*, set tia_gain = cfg_gain, clear range_err and the gain-change counter, load the settle counter, then go to SETTLE.
REQ-018 start while busy SHALL be ignored, including start in the DONE cycle.
REQ-019 SETTLE SHALL last exactly cfg_settle cycles; cfg_settle = 0 SHALL pass through SETTLE in one cycle.
REQ-020 SETTLE exits to PROBE, or to ACCUM when autoranging is disabled.
REQ-021 adc_req SHALL be held high until the cycle it is sampled with adc_ack = 1, then SHALL go low for at least one cycle; adc_ack while adc_req is low SHALL be ignored.
REQ-022 PROBE SHALL take one sample, which is not accumulated:
  - data >= HI_THR and gain > 0: decrement gain, go to SETTLE.
  - data <= LO_THR and gain < 3: increment gain, go to SETTLE.
  - otherwise: go to ACCUM.
REQ-023 data >= HI_THR at gain 0 SHALL set range_err and proceed to ACCUM; data <= LO_THR at gain 3 SHALL proceed to ACCUM with no error.
REQ-024 On the 7th requested gain change, the gain SHALL remain unchanged, range_err SHALL be set and the block SHALL go to ACCUM.
REQ-025 ACCUM SHALL perform 2^n handshakes into an accumulator of ADC_W+MAX_AVG_LOG2 bits, without overflow.
REQ-026 In ACCUM, any sample >= HI_THR SHALL set range_err.
REQ-027 DONE: result = accumulator >> n (truncated) and result_gain = tia_gain, both registered; done high for exactly one cycle; the next state is IDLE.
REQ-028 result, result_gain and range_err SHALL hold until the next start.
REQ-029 abort in any non-IDLE state: IDLE on the next cycle, adc_req low, no done, result unchanged.
REQ-030 abort SHALL take priority over a simultaneous adc_ack.
REQ-031 tia_gain SHALL hold its last value after abort.

Reset
REQ-032 ARESET SHALL force state IDLE and drive tia_gain, adc_req, busy, done, range_err, result and result_gain to 0.
REQ-033 ARESET SHALL clear all counters and the accumulator, take priority over start and abort, and apply identically mid-operation.

Configuration
REQ-034 Macro TIA_AUTORANGE_EN defined: PROBE state and gain stepping are included as specified.
REQ-035 Macro TIA_AUTORANGE_EN undefined: PROBE is omitted, SETTLE goes directly to ACCUM, and tia_gain stays at cfg_gain for the whole measurement.
REQ-036 With TIA_AUTORANGE_EN undefined, range_err SHALL be set only per REQ-026.

Verification
REQ-037 cfg_gain=2, settle=3, avg_log2=2, ADC always returns 0x800 -> 1 probe + 4 accumulation handshakes, result=0x800, result_gain=2, done pulse of 1 cycle, range_err=0.
REQ-038 cfg_gain=3, probe returns 0xFFF then 0x400, then 0x400 throughout -> tia_gain goes 3->2, SETTLE is rerun for 3 cycles, result=0x400, result_gain=2.
REQ-039 cfg_gain=0, ADC always returns 0xFFF -> no gain change, range_err=1, result=0xFFF.
REQ-040 avg_log2=3, accumulation samples 0x100..0x107 -> sum 0x81C, result=0x103.
REQ-041 abort asserted in the same cycle as the 2nd accumulation adc_ack -> adc_req=0 and busy=0 next cycle, done never pulses, result keeps its prior value.
REQ-042 TIA_AUTORANGE_EN undefined, cfg_gain=3, ADC returns 0xFFF -> tia_gain=3 throughout, no probe handshake occurs, range_err=1.

Source files
------------

// File: rtl/tia_range_sequencer.sv
// Transimpedance-amplifier range sequencer: settles, optionally autoranges the TIA gain, then
// averages 2^n ADC samples. Define TIA_AUTORANGE_EN to include the PROBE state and gain stepping.
`timescale 1ns / 1ps
module tia_range_sequencer #(
  parameter int unsigned      ADC_W        = 12,
  parameter int unsigned      SETTLE_W     = 16,
  parameter logic [ADC_W-1:0] HI_THR       = 12'hF00,
  parameter logic [ADC_W-1:0] LO_THR       = 12'h0FF,
  parameter int unsigned      MAX_AVG_LOG2 = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          cfg_gain,
  input  logic [SETTLE_W-1:0] cfg_settle,
  input  logic [2:0]          cfg_avg_log2,
  output logic [1:0]          tia_gain,
  output logic                adc_req,
  input  logic                adc_ack,
  input  logic [ADC_W-1:0]    adc_data,
  output logic                busy,
  output logic                done,
  output logic                range_err,
  output logic [ADC_W-1:0]    result,
  output logic [1:0]          result_gain
);

  localparam int unsigned ACC_W = ADC_W + MAX_AVG_LOG2;
  localparam int unsigned CNT_W = MAX_AVG_LOG2 + 1;

  typedef enum logic [2:0] {StIdle, StSettle, StProbe, StAccum, StDone} state_e;

  state_e              state_q;
  logic [SETTLE_W-1:0] settle_cnt_q;
  logic [2:0]          avg_log2_q;
  logic [CNT_W-1:0]    smp_cnt_q;
  logic [ACC_W-1:0]    acc_q;

  logic [2:0]       avg_clip;
  logic [ACC_W-1:0] acc_sum;
  logic             last_smp;
  logic             hi;

  assign avg_clip = (cfg_avg_log2 > 3'(MAX_AVG_LOG2)) ? 3'(MAX_AVG_LOG2) : cfg_avg_log2;
  assign acc_sum  = acc_q + ACC_W'(adc_data);
  assign last_smp = (smp_cnt_q == ((CNT_W'(1) << avg_log2_q) - CNT_W'(1)));
  assign hi       = (adc_data >= HI_THR);

`ifdef TIA_AUTORANGE_EN
  logic [SETTLE_W-1:0] settle_cfg_q;
  logic [2:0]          chg_cnt_q;
  logic                lo;
  logic                step_dn;
  logic                step_up;

  assign lo      = (adc_data <= LO_THR);
  assign step_dn = hi && (tia_gain != 2'd0);
  assign step_up = lo && (tia_gain != 2'd3);
`else
  logic unused_lo;
  assign unused_lo = (adc_data <= LO_THR);
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= StIdle;
      settle_cnt_q <= '0;
      avg_log2_q   <= '0;
      smp_cnt_q    <= '0;
      acc_q        <= '0;
      tia_gain     <= '0;
      adc_req      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      range_err    <= 1'b0;
      result       <= '0;
      result_gain  <= '0;
`ifdef TIA_AUTORANGE_EN
      settle_cfg_q <= '0;
      chg_cnt_q    <= '0;
`endif
    end else if (abort && (state_q != StIdle)) begin
      // Abort wins over a coincident adc_ack; the sample is dropped and gain is left as is.
      state_q <= StIdle;
      adc_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q      <= StSettle;
            settle_cnt_q <= cfg_settle;
            avg_log2_q   <= avg_clip;
            smp_cnt_q    <= '0;
            acc_q        <= '0;
            tia_gain     <= cfg_gain;
            range_err    <= 1'b0;
            busy         <= 1'b1;
`ifdef TIA_AUTORANGE_EN
            settle_cfg_q <= cfg_settle;
            chg_cnt_q    <= '0;
`endif
          end
        end
        StSettle: begin
          // A count of 0 or 1 both leave after this single cycle.
          if (settle_cnt_q <= SETTLE_W'(1)) begin
`ifdef TIA_AUTORANGE_EN
            state_q <= StProbe;
`else
            state_q <= StAccum;
`endif
          end else begin
            settle_cnt_q <= settle_cnt_q - SETTLE_W'(1);
          end
        end
        StProbe: begin
`ifdef TIA_AUTORANGE_EN
          if (!adc_req) begin
            adc_req <= 1'b1;
          end else if (adc_ack) begin
            adc_req <= 1'b0;
            if (step_dn || step_up) begin
              if (chg_cnt_q == 3'd6) begin
                range_err <= 1'b1;
                state_q   <= StAccum;
              end else begin
                chg_cnt_q    <= chg_cnt_q + 3'd1;
                tia_gain     <= step_dn ? tia_gain - 2'd1 : tia_gain + 2'd1;
                settle_cnt_q <= settle_cfg_q;
                state_q      <= StSettle;
              end
            end else begin
              // Saturated at the lowest gain: nothing left to step to.
              if (hi) range_err <= 1'b1;
              state_q <= StAccum;
            end
          end
`else
          state_q <= StIdle;
`endif
        end
        StAccum: begin
          if (!adc_req) begin
            adc_req <= 1'b1;
          end else if (adc_ack) begin
            adc_req <= 1'b0;
            acc_q   <= acc_sum;
            if (hi) range_err <= 1'b1;
            if (last_smp) begin
              result      <= ADC_W'(acc_sum >> avg_log2_q);
              result_gain <= tia_gain;
              done        <= 1'b1;
              state_q     <= StDone;
            end else begin
              smp_cnt_q <= smp_cnt_q + CNT_W'(1);
            end
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          adc_req <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tia_range_sequencer.sv
// Directed bench for tia_range_sequencer with a one-cycle-latency ADC responder.
// Expected values follow whether TIA_AUTORANGE_EN is defined for the build.
`timescale 1ns / 1ps
module tb_tia_range_sequencer;

`ifdef TIA_AUTORANGE_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic        abort;
  logic [1:0]  cfg_gain;
  logic [15:0] cfg_settle;
  logic [2:0]  cfg_avg_log2;
  logic [1:0]  tia_gain;
  logic        adc_req;
  logic        adc_ack;
  logic [11:0] adc_data;
  logic        busy;
  logic        done;
  logic        range_err;
  logic [11:0] result;
  logic [1:0]  result_gain;

  int checks = 0;
  int failures = 0;

  int          hs_cnt = 0;
  int          abort_at = 0;
  logic [11:0] adc_dflt = 12'h000;
  logic [11:0] adc_q[$];
  logic [1:0]  gain_log[$];

  tia_range_sequencer dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .start       (start),
    .abort       (abort),
    .cfg_gain    (cfg_gain),
    .cfg_settle  (cfg_settle),
    .cfg_avg_log2(cfg_avg_log2),
    .tia_gain    (tia_gain),
    .adc_req     (adc_req),
    .adc_ack     (adc_ack),
    .adc_data    (adc_data),
    .busy        (busy),
    .done        (done),
    .range_err   (range_err),
    .result      (result),
    .result_gain (result_gain)
  );

  initial forever #5 ACLK = ~ACLK;

  // ADC model: acks one cycle after seeing a fresh request; optionally fires abort with an ack.
  initial begin
    adc_ack  = 1'b0;
    adc_data = '0;
    abort    = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      abort = 1'b0;
      if (adc_req && !adc_ack) begin
        adc_ack  = 1'b1;
        adc_data = (adc_q.size() > 0) ? adc_q.pop_front() : adc_dflt;
        gain_log.push_back(tia_gain);
        hs_cnt++;
        if (hs_cnt == abort_at) abort = 1'b1;
      end else begin
        adc_ack = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns cycles from start edge to done, handshakes and gain-log base.
  task automatic run_meas(input logic [1:0] g, input logic [15:0] s, input logic [2:0] n,
                          input bit start_in_done, output int cyc, output int n_hs,
                          output int glog_base);
    int hs_base;
    hs_base      = hs_cnt;
    glog_base    = gain_log.size();
    cfg_gain     = g;
    cfg_settle   = s;
    cfg_avg_log2 = n;
    start        = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    cyc   = 0;
    while (!done && cyc < 400) begin
      @(negedge ACLK);
      cyc++;
    end
    check_eq("done_seen", done, 1'b1);
    check_eq("busy_in_done", busy, 1'b1);
    if (start_in_done) begin
      cfg_gain = ~g;
      start    = 1'b1;
    end
    @(negedge ACLK);
    start = 1'b0;
    check_eq("done_one_cycle", done, 1'b0);
    check_eq("idle_after_done", busy, 1'b0);
    n_hs = hs_cnt - hs_base;
  endtask

  initial begin
    int cyc;
    int n_hs;
    int gb;
    int hs_base;
    int done_cnt;

    // Reset, with start held high to show reset priority.
    ARESET       = 1'b1;
    start        = 1'b1;
    cfg_gain     = 2'd3;
    cfg_settle   = 16'd2;
    cfg_avg_log2 = 3'd1;
    repeat (3) @(negedge ACLK);
    check_eq("rst_tia_gain", tia_gain, 2'd0);
    check_eq("rst_adc_req", adc_req, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_range_err", range_err, 1'b0);
    check_eq("rst_result", result, 12'h000);
    check_eq("rst_result_gain", result_gain, 2'd0);
    start  = 1'b0;
    ARESET = 1'b0;
    @(negedge ACLK);

    // Mid-range signal at gain 2; a start during DONE must be ignored.
    adc_dflt = 12'h800;
    run_meas(2'd2, 16'd3, 3'd2, 1'b1, cyc, n_hs, gb);
    check_eq("t1_cycles", cyc, AR ? 13 : 11);
    check_eq("t1_handshakes", n_hs, AR ? 5 : 4);
    check_eq("t1_result", result, 12'h800);
    check_eq("t1_result_gain", result_gain, 2'd2);
    check_eq("t1_range_err", range_err, 1'b0);
    check_eq("t1_tia_gain", tia_gain, 2'd2);

    // Abort together with the 2nd accumulation ack.
    hs_base      = hs_cnt;
    abort_at     = hs_cnt + (AR ? 3 : 2);
    cfg_gain     = 2'd2;
    cfg_settle   = 16'd3;
    cfg_avg_log2 = 3'd2;
    start        = 1'b1;
    @(negedge ACLK);
    start    = 1'b0;
    cyc      = 0;
    done_cnt = 0;
    while (hs_cnt < abort_at && cyc < 100) begin
      @(negedge ACLK);
      cyc++;
      if (done) done_cnt++;
    end
    check_eq("ab_abort_with_ack", abort, 1'b1);
    check_eq("ab_ack_with_abort", adc_ack, 1'b1);
    @(negedge ACLK);
    check_eq("ab_adc_req", adc_req, 1'b0);
    check_eq("ab_busy", busy, 1'b0);
    repeat (12) begin
      @(negedge ACLK);
      if (done) done_cnt++;
    end
    check_eq("ab_no_done", done_cnt, 0);
    check_eq("ab_no_more_hs", hs_cnt - hs_base, AR ? 3 : 2);
    check_eq("ab_result_kept", result, 12'h800);
    check_eq("ab_result_gain_kept", result_gain, 2'd2);
    check_eq("ab_tia_gain_held", tia_gain, 2'd2);
    abort_at = 0;

    // Saturated first probe at gain 3, then mid-range.
    adc_q.push_back(12'hFFF);
    adc_dflt = 12'h400;
    run_meas(2'd3, 16'd3, 3'd2, 1'b0, cyc, n_hs, gb);
    check_eq("t2_cycles", cyc, AR ? 18 : 11);
    check_eq("t2_handshakes", n_hs, AR ? 6 : 4);
    check_eq("t2_gain_hs0", gain_log[gb], 2'd3);
    check_eq("t2_gain_hs1", gain_log[gb+1], AR ? 2'd2 : 2'd3);
    check_eq("t2_result", result, AR ? 12'h400 : 12'h6FF);
    check_eq("t2_result_gain", result_gain, AR ? 2'd2 : 2'd3);
    check_eq("t2_range_err", range_err, AR ? 1'b0 : 1'b1);

    // Saturation at lowest gain.
    adc_dflt = 12'hFFF;
    run_meas(2'd0, 16'd3, 3'd1, 1'b0, cyc, n_hs, gb);
    check_eq("t3_handshakes", n_hs, AR ? 3 : 2);
    check_eq("t3_result", result, 12'hFFF);
    check_eq("t3_result_gain", result_gain, 2'd0);
    check_eq("t3_tia_gain", tia_gain, 2'd0);
    check_eq("t3_range_err", range_err, 1'b1);

    // Eight ramped samples: sum 0x81C truncates to 0x103.
    if (AR) adc_q.push_back(12'h800);
    for (int i = 0; i < 8; i++) adc_q.push_back(12'h100 + 12'(i));
    run_meas(2'd1, 16'd2, 3'd3, 1'b0, cyc, n_hs, gb);
    check_eq("t4_handshakes", n_hs, AR ? 9 : 8);
    check_eq("t4_result", result, 12'h103);
    check_eq("t4_range_err", range_err, 1'b0);

    // Underrange at gain 3 with zero settle and avg_log2 clipped from 7 to 4.
    adc_dflt = 12'h050;
    run_meas(2'd3, 16'd0, 3'd7, 1'b0, cyc, n_hs, gb);
    check_eq("t5_cycles", cyc, AR ? 35 : 33);
    check_eq("t5_handshakes", n_hs, AR ? 17 : 16);
    check_eq("t5_result", result, 12'h050);
    check_eq("t5_result_gain", result_gain, 2'd3);
    check_eq("t5_range_err", range_err, 1'b0);

`ifdef TIA_AUTORANGE_EN
    // Oscillating probe: the 7th gain change is refused.
    for (int i = 0; i < 7; i++) adc_q.push_back((i % 2 == 0) ? 12'h000 : 12'hFFF);
    adc_dflt = 12'h800;
    run_meas(2'd0, 16'd1, 3'd0, 1'b0, cyc, n_hs, gb);
    check_eq("t6_handshakes", n_hs, 8);
    check_eq("t6_gain_hs5", gain_log[gb+5], 2'd1);
    check_eq("t6_gain_hs7", gain_log[gb+7], 2'd0);
    check_eq("t6_result", result, 12'h800);
    check_eq("t6_result_gain", result_gain, 2'd0);
    check_eq("t6_range_err", range_err, 1'b1);
`endif

    // Reset in the middle of a measurement.
    adc_dflt     = 12'h400;
    cfg_gain     = 2'd3;
    cfg_settle   = 16'd2;
    cfg_avg_log2 = 3'd3;
    start        = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    repeat (8) @(negedge ACLK);
    check_eq("mr_busy_before", busy, 1'b1);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    check_eq("mr_busy", busy, 1'b0);
    check_eq("mr_adc_req", adc_req, 1'b0);
    check_eq("mr_tia_gain", tia_gain, 2'd0);
    check_eq("mr_result", result, 12'h000);
    check_eq("mr_result_gain", result_gain, 2'd0);
    check_eq("mr_range_err", range_err, 1'b0);
    @(negedge ACLK);
    check_eq("mr_stays_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
